// File: rtl/branch_ex_pkg.sv
// Shared definitions for the branch execution unit.
// Holds the opcode encodings, the opcode type and a legality helper.
package branch_ex_pkg;

    localparam int OP_W = 4;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP  = 4'd0;
    localparam op_t OP_BEQ  = 4'd1;
    localparam op_t OP_BNE  = 4'd2;
    localparam op_t OP_BLT  = 4'd3;
    localparam op_t OP_BGE  = 4'd4;
    localparam op_t OP_BLTU = 4'd5;
    localparam op_t OP_BGEU = 4'd6;
    localparam op_t OP_JAL  = 4'd7;
    localparam op_t OP_JALR = 4'd8;

    // True for every opcode this unit resolves.
    function automatic logic op_legal(input op_t op);
        return (op >= OP_BEQ) && (op <= OP_JALR);
    endfunction

endpackage

// File: rtl/branch_ex_if.sv
// Branch unit bus: the issue pulse from the branch RS, the redirect to
// fetch with its acknowledge, and the back-pressure signal.
//   master : RS/fetch side (drives the issue fields and jumpAck)
//   slave  : branch_ex side (drives jumpValid, jumpAddr, brBusy)
interface branch_ex_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    import branch_ex_pkg::*;

    logic              BranchWorkEn;
    logic [DATA_W-1:0] operandO;
    logic [DATA_W-1:0] operandT;
    logic [DATA_W-1:0] imm;
    op_t               opCode;
    logic [ADDR_W-1:0] PC;
    logic              jumpValid;
    logic [ADDR_W-1:0] jumpAddr;
    logic              jumpAck;
    logic              brBusy;

    modport master (
        output BranchWorkEn, operandO, operandT, imm, opCode, PC, jumpAck,
        input  jumpValid, jumpAddr, brBusy
    );

    modport slave (
        input  BranchWorkEn, operandO, operandT, imm, opCode, PC, jumpAck,
        output jumpValid, jumpAddr, brBusy
    );
endinterface

// File: rtl/branch_ex_cmp.sv
// branch_cmp: purely combinational branch resolver.
// Inputs : opcode, rs1/rs2 operands, immediate, PC.
// Outputs: taken (condition true / jump), target address, legal opcode.
module branch_cmp
    import branch_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] opnd_o,
    input  logic [DATA_W-1:0] opnd_t,
    input  logic [DATA_W-1:0] imm,
    input  logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic [ADDR_W-1:0] target,
    output logic              legal
);
    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] reg_rel;

    // Both sums wrap naturally at the address width.
    assign pc_rel  = pc + ADDR_W'(imm);
    assign reg_rel = ADDR_W'(opnd_o) + ADDR_W'(imm);

    always_comb begin
        taken  = 1'b0;
        target = pc_rel;
        legal  = op_legal(op);
        unique case (op)
            OP_BEQ:  taken = (opnd_o == opnd_t);
            OP_BNE:  taken = (opnd_o != opnd_t);
            OP_BLT:  taken = ($signed(opnd_o) <  $signed(opnd_t));
            OP_BGE:  taken = ($signed(opnd_o) >= $signed(opnd_t));
            OP_BLTU: taken = (opnd_o <  opnd_t);
            OP_BGEU: taken = (opnd_o >= opnd_t);
            OP_JAL:  taken = 1'b1;
            OP_JALR: begin
                taken  = 1'b1;
                target = {reg_rel[ADDR_W-1:1], 1'b0};
            end
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_ex.sv
// branch_ex: branch execution unit.
// Resolves the issued branch in the issue cycle and registers any taken
// result into a one-deep redirect slot that is held until fetch acks it.
// Ports:
//   clk, rst (async active-low), rdy (global enable)
//   bus        : branch_ex_if.slave (issue, redirect, ack, brBusy)
//   brCount    : legal branches resolved
//   takenCount : taken results (including dropped ones)
//   overflowErr: sticky, a taken result hit a full slot
//   illegalOp  : sticky, issue with a non-branch opcode
module branch_ex
    import branch_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    branch_ex_if.slave       bus,
    output logic [CNT_W-1:0] brCount,
    output logic [CNT_W-1:0] takenCount,
    output logic             overflowErr,
    output logic             illegalOp
);
    logic              cmp_taken;
    logic              cmp_legal;
    logic [ADDR_W-1:0] cmp_target;

    logic              jvalid_q, jvalid_d;
    logic [ADDR_W-1:0] jaddr_q,  jaddr_d;
    logic [CNT_W-1:0]  brcnt_q,  brcnt_d;
    logic [CNT_W-1:0]  tkcnt_q,  tkcnt_d;
    logic              ovf_q,    ovf_d;
    logic              ill_q,    ill_d;

    logic issue;
    logic take;
    logic ack;

    branch_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cmp (
        .op     (bus.opCode),
        .opnd_o (bus.operandO),
        .opnd_t (bus.operandT),
        .imm    (bus.imm),
        .pc     (bus.PC),
        .taken  (cmp_taken),
        .target (cmp_target),
        .legal  (cmp_legal)
    );

    // rdy gates every input event so a frozen cycle is a true no-op.
    assign issue = bus.BranchWorkEn & rdy;
    assign take  = issue & cmp_legal & cmp_taken;
    assign ack   = bus.jumpAck & rdy;

    always_comb begin
        jvalid_d = jvalid_q;
        jaddr_d  = jaddr_q;
        brcnt_d  = brcnt_q;
        tkcnt_d  = tkcnt_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;

        // An ack in the same cycle frees the slot for the new redirect.
        if (take && (!jvalid_q || ack)) begin
            jvalid_d = 1'b1;
            jaddr_d  = cmp_target;
        end else if (take) begin
            ovf_d = 1'b1;
        end else if (ack && jvalid_q) begin
            jvalid_d = 1'b0;
        end

        if (issue && cmp_legal) begin
            brcnt_d = brcnt_q + CNT_W'(1);
            if (cmp_taken) tkcnt_d = tkcnt_q + CNT_W'(1);
        end
        if (issue && !cmp_legal) ill_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jvalid_q <= 1'b0;
            jaddr_q  <= '0;
            brcnt_q  <= '0;
            tkcnt_q  <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            jvalid_q <= jvalid_d;
            jaddr_q  <= jaddr_d;
            brcnt_q  <= brcnt_d;
            tkcnt_q  <= tkcnt_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign bus.jumpValid = jvalid_q;
    assign bus.jumpAddr  = jaddr_q;
    // Raw jumpAck, not rdy-gated: back-pressure is a pure view of the slot.
    assign bus.brBusy    = jvalid_q & ~bus.jumpAck;
    assign brCount       = brcnt_q;
    assign takenCount    = tkcnt_q;
    assign overflowErr   = ovf_q;
    assign illegalOp     = ill_q;
endmodule

// File: doc/branch_ex.md
Name: branch_ex

Overview:
- Branch execution unit at the far end of the branch RS issue interface.
- Consumes the one-cycle issue pulse: work enable, two operands, immediate, opcode, PC.
- Resolves the condition and computes the target. Static predict-not-taken, so every taken branch or jump produces a registered redirect to fetch.
- The redirect is held until fetch acknowledges it. Also provides back-pressure and performance counters.

Parameters:
- DATA_W, 32, operand/immediate width (matches `DataBus`)
- ADDR_W, 32, PC/target width (matches `InstAddrBus`)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- BranchWorkEn  in  1  issue valid from branch RS, one-cycle pulse
- operandO  in  DATA_W  rs1 value
- operandT  in  DATA_W  rs2 value
- imm  in  DATA_W  sign-extended offset
- opCode  in  `OpBus`  branch opcode
- PC  in  ADDR_W  instruction address
- jumpValid  out  1  redirect request pending
- jumpAddr  out  ADDR_W  redirect target
- jumpAck  in  1  fetch accepts redirect
- brBusy  out  1  redirect slot occupied and not being acked; dispatcher must hold branch issue
- brCount  out  CNT_W  resolved branch/jump instructions
- takenCount  out  CNT_W  redirects generated
- overflowErr  out  1  sticky: taken result dropped because slot full
- illegalOp  out  1  sticky: BranchWorkEn with a non-branch opcode

Behaviour:
- Reset (rst low, async): jumpValid=0, jumpAddr=0, brCount=0, takenCount=0, overflowErr=0, illegalOp=0.
- rdy low: no register changes. BranchWorkEn and jumpAck are ignored that cycle.
- Resolve happens combinationally in the issue cycle N (BranchWorkEn & rdy). Results are registered at the end of N; jumpValid/jumpAddr are visible in N+1. Latency is 1 cycle.
- Conditions, signed unless noted:
  - BEQ: O==T
  - BNE: O!=T
  - BLT: O<T
  - BGE: O>=T
  - BLTU: O<T unsigned
  - BGEU: O>=T unsigned
  - JAL, JALR: always taken
- Targets:
  - branches and JAL: PC+imm, modulo 2^ADDR_W
  - JALR: (operandO+imm) with bit0 forced 0
- Any other opcode: not taken, no counter change, illegalOp set to 1.
- Redirect slot (depth 1), evaluated in priority order at each enabled edge:
  - If taken and (slot empty or jumpAck): load jumpAddr, jumpValid=1.
  - Else if taken and slot full and no jumpAck: drop the new result, set overflowErr=1; existing redirect unchanged.
  - Else if jumpAck and jumpValid: jumpValid=0; jumpAddr keeps its last value.
  - jumpAck while jumpValid=0 has no effect.
- brBusy = jumpValid & ~jumpAck (combinational).
- Counters, per valid opcode:
  - brCount increments on each legal resolve.
  - takenCount increments on each taken resolve, including a dropped one.
  - Both wrap at 2^CNT_W.
- Sticky flags clear only on reset.
- Reset mid-operation: a pending redirect is discarded; no ack is required afterwards.

Decomposition:
- Opcode encodings (BEQ..JALR), `DataBus`, `OpBus`, `InstAddrBus`, `dataFree`, `addrFree` come from shared defines.v.
- Sub-module branch_cmp (combinational): takes opcode, operands, imm and PC; returns taken, target and legal.
- branch_ex holds the redirect slot, counters and flags.

Test Plan:
- BEQ, O=5, T=5, PC=0x100, imm=0x20 -> next cycle jumpValid=1, jumpAddr=0x120; brCount=1, takenCount=1. With jumpAck high one cycle -> jumpValid=0.
- Signedness, O=0xFFFFFFFF, T=1:
  - BLT -> taken.
  - BLTU -> not taken: jumpValid stays 0, brCount increments, takenCount does not.
- JALR, O=0x1001, imm=0x4 -> jumpAddr=0x1004. JAL, PC=0x10, imm=0xFFFFFFF0 -> jumpAddr=0x0.
- Hold jumpAck low after a taken BNE -> brBusy=1. Issue another taken BEQ -> overflowErr=1, jumpAddr unchanged, takenCount=2. Next cycle, ack plus a new taken branch in the same cycle -> slot reloads, jumpValid stays 1.
- Pending redirect, then rst low mid-cycle -> all outputs 0 immediately.
- rdy=0 with BranchWorkEn=1 -> no state change.
- Opcode NOP with BranchWorkEn=1 -> illegalOp=1, counters unchanged.
